// File: rtl/traffic_light_ctrl.sv
// Two-way traffic-light phase controller: prescaled tick, six timed phases,
// pedestrian shortening of green, and a maintenance flash mode.
module traffic_light_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_PED    = 5
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [0:0] SW,
    output logic [4:0] LEDR,
    output logic [7:0] LEDG
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [4:0] DUR_GREEN  = 5'(T_GREEN);
    localparam logic [4:0] DUR_YELLOW = 5'(T_YELLOW);
    localparam logic [4:0] DUR_ALLRED = 5'(T_ALLRED);
    localparam logic [4:0] DUR_PED    = 5'(T_PED);

    localparam logic [5:0] LAMPS_ALLRED = 6'b100100;
    localparam logic [5:0] LAMPS_NS_GRN = 6'b100001;
    localparam logic [5:0] LAMPS_NS_YEL = 6'b100010;
    localparam logic [5:0] LAMPS_EW_GRN = 6'b001100;
    localparam logic [5:0] LAMPS_EW_YEL = 6'b010100;

    typedef enum logic [2:0] {
        AR_A   = 3'd0,
        NS_GRN = 3'd1,
        NS_YEL = 3'd2,
        AR_B   = 3'd3,
        EW_GRN = 3'd4,
        EW_YEL = 3'd5,
        FLASH  = 3'd6
    } phaseT;

    logic          rstN;
    logic          keyMeta_q, keySync_q, keyPrev_q;
    logic          swMeta_q, swSync_q;
    logic          pedPress;

    logic [PW-1:0] presc_q, presc_d;
    logic          tickNow;
    logic          tick_q;

    phaseT         state_q, state_d;
    logic [4:0]    remain_q, remain_d;
    logic          flashPh_q, flashPh_d;
    logic          pedPend_q, pedPend_d;
    logic [5:0]    lamps_q, lamps_d;

    logic          isGreen;
    logic          allRedEntry;

    assign rstN = KEY[0];

    function automatic phaseT nextPhase(input phaseT s);
        phaseT n;
        case (s)
            AR_A:    n = NS_GRN;
            NS_GRN:  n = NS_YEL;
            NS_YEL:  n = AR_B;
            AR_B:    n = EW_GRN;
            EW_GRN:  n = EW_YEL;
            EW_YEL:  n = AR_A;
            default: n = AR_A;
        endcase
        return n;
    endfunction

    function automatic logic [4:0] phaseDuration(input phaseT s);
        logic [4:0] d;
        case (s)
            AR_A, AR_B:     d = DUR_ALLRED;
            NS_GRN, EW_GRN: d = DUR_GREEN;
            NS_YEL, EW_YEL: d = DUR_YELLOW;
            default:        d = 5'd0;
        endcase
        return d;
    endfunction

    // Button and switch are asynchronous; the extra key flop gives a one-cycle press pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!rstN) begin
            keyMeta_q <= 1'b0;
            keySync_q <= 1'b0;
            keyPrev_q <= 1'b0;
            swMeta_q  <= 1'b0;
            swSync_q  <= 1'b0;
        end else begin
            keyMeta_q <= KEY[1];
            keySync_q <= keyMeta_q;
            keyPrev_q <= keySync_q;
            swMeta_q  <= SW[0];
            swSync_q  <= swMeta_q;
        end
    end

    assign pedPress = keyPrev_q & ~keySync_q;

    assign tickNow = (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tickNow) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rstN) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tickNow;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rstN) begin
            state_q   <= AR_A;
            remain_q  <= DUR_ALLRED;
            flashPh_q <= 1'b0;
            pedPend_q <= 1'b0;
            lamps_q   <= LAMPS_ALLRED;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            flashPh_q <= flashPh_d;
            pedPend_q <= pedPend_d;
            lamps_q   <= lamps_d;
        end
    end

    assign isGreen = (state_q == NS_GRN) || (state_q == EW_GRN);

    // Priority: flash, flash exit, pedestrian shorten (swallows a coincident tick), tick.
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        flashPh_d = flashPh_q;
        if (swSync_q) begin
            state_d  = FLASH;
            remain_d = 5'd0;
            if (state_q != FLASH) begin
                flashPh_d = 1'b0;
            end else if (tickNow) begin
                flashPh_d = ~flashPh_q;
            end
        end else if (state_q == FLASH) begin
            state_d   = AR_A;
            remain_d  = DUR_ALLRED;
            flashPh_d = 1'b0;
        end else if (pedPend_q && isGreen && (remain_q > DUR_PED)) begin
            remain_d = DUR_PED;
        end else if (tickNow) begin
            if (remain_q == 5'd1) begin
                state_d  = nextPhase(state_q);
                remain_d = phaseDuration(nextPhase(state_q));
            end else begin
                remain_d = remain_q - 5'd1;
            end
        end
    end

    assign allRedEntry = ((state_d == AR_A) || (state_d == AR_B)) && (state_d != state_q);

    always_comb begin
        pedPend_d = pedPend_q;
        if (pedPress) begin
            pedPend_d = 1'b1;
        end else if (allRedEntry) begin
            pedPend_d = 1'b0;
        end
    end

    // Lamps decode from the next state so the registered lamps line up with state_q.
    always_comb begin
        lamps_d = LAMPS_ALLRED;
        case (state_d)
            AR_A, AR_B: lamps_d = LAMPS_ALLRED;
            NS_GRN:     lamps_d = LAMPS_NS_GRN;
            NS_YEL:     lamps_d = LAMPS_NS_YEL;
            EW_GRN:     lamps_d = LAMPS_EW_GRN;
            EW_YEL:     lamps_d = LAMPS_EW_YEL;
            FLASH:      lamps_d = {1'b0, flashPh_d, 1'b0, 1'b0, flashPh_d, 1'b0};
            default:    lamps_d = LAMPS_ALLRED;
        endcase
    end

    assign LEDR = remain_q;
    assign LEDG = {tick_q, pedPend_q, lamps_q};

endmodule
